// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// FSM state encoding and the adder slice width.
package adder_ctrl_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step counter must be at least one bit wide even for a single-slice adder
   function automatic int cnt_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/add_slice4.sv
// 4-bit combinational ripple adder; the only arithmetic on operand bits
// anywhere in the serial adder.
module add_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: accepts a, b, cin and produces a+b+cin one 4-bit
// slice per cycle, presenting the result under a valid/ready handshake.
module serial_add_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CW     = cnt_width(NSLICE);

   state_t           state;
   state_t           nextstate;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sumreg;
   logic [WIDTH-1:0] sumnext;
   logic [WIDTH-1:0] resreg;
   logic             carry;
   logic             rescarry;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             laststep;
   logic [3:0]       slicesum;
   logic             slicecout;

   add_slice4 u_slice (
      .a    (areg[SLICE_W-1:0]),
      .b    (breg[SLICE_W-1:0]),
      .cin  (carry),
      .sum  (slicesum),
      .cout (slicecout)
   );

   assign accept   = (state == IDLE) && in_valid;
   assign laststep = (state == RUN) && (cnt == CW'(NSLICE - 1));
   assign sumnext  = WIDTH'({slicesum, sumreg} >> SLICE_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextstate;
      end
   end

   always_comb begin
      nextstate = state;
      case (state)
         IDLE:    if (in_valid) nextstate = RUN;
         RUN:     if (laststep) nextstate = DONE;
         DONE:    if (out_ready) nextstate = IDLE;
         default: nextstate = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even before the clearing edge
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      sum       = '0;
      cout      = 1'b0;
      if (!rst) begin
         in_ready  = (state == IDLE);
         out_valid = (state == DONE);
         sum       = resreg;
         cout      = rescarry;
      end
   end

   // The result is copied out on the final step so sum/cout never show partial work
   always_ff @(posedge clk) begin
      if (rst) begin
         areg     <= '0;
         breg     <= '0;
         sumreg   <= '0;
         resreg   <= '0;
         carry    <= 1'b0;
         rescarry <= 1'b0;
         cnt      <= '0;
      end else if (accept) begin
         areg   <= a;
         breg   <= b;
         carry  <= cin;
         sumreg <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         areg   <= areg >> SLICE_W;
         breg   <= breg >> SLICE_W;
         sumreg <= sumnext;
         carry  <= slicecout;
         cnt    <= cnt + 1'b1;
         if (laststep) begin
            resreg   <= sumnext;
            rescarry <= slicecout;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=16): fixed vectors,
// handshake/reset corner sequences and randomized operations.
module tb_serial_add_ctrl;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   typedef struct {
      logic [WIDTH-1:0] va;
      logic [WIDTH-1:0] vb;
      logic             vcin;
      int               hold;
      logic [WIDTH-1:0] expsum;
      logic             expcout;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             out_valid;
   logic             out_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One full transaction: accept, scramble inputs during RUN, wait, hold, release
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tcin, input int hold,
                                input logic [WIDTH-1:0] expsum, input logic expcout);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
      a         = ta;
      b         = tb;
      cin       = tcin;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         a   = WIDTH'($urandom);
         b   = WIDTH'($urandom);
         cin = 1'($urandom);
         step();
         lat++;
      end
      checkOutput("latency", lat, NSLICE);
      checkOutput("sum", {16'b0, sum}, {16'b0, expsum});
      checkOutput("cout", {31'b0, cout}, {31'b0, expcout});
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         step();
         checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("hold_sum", {16'b0, sum}, {16'b0, expsum});
         checkOutput("hold_cout", {31'b0, cout}, {31'b0, expcout});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("release_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   vec_t vecs[$];

   initial begin
      logic [WIDTH:0] model;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      int               t;
      int               readyat;
      int               acceptat;

      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 6, 16'h0000, 1'b1});
      vecs.push_back('{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1});
      vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0});

      // Reset state, including outputs while rst is still asserted
      rst = 1'b1;
      step();
      step();
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_sum", {16'b0, sum}, 32'd0);
      checkOutput("rst_cout", {31'b0, cout}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      $display("[TB] fixed vectors");
      foreach (vecs[i])
         applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].hold,
                       vecs[i].expsum, vecs[i].expcout);

      $display("[TB] reset during RUN");
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      checkOutput("midrun_rst_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      checkOutput("midrun_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrun_sum", {16'b0, sum}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("midrun_release_in_ready", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < NSLICE + 1; i++) begin
         step();
         checkOutput("midrun_no_valid", {31'b0, out_valid}, 32'd0);
      end
      applyStimulus(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0);

      $display("[TB] reset during DONE");
      a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < NSLICE; i++) step();
      checkOutput("middone_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checkOutput("middone_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("middone_in_ready", {31'b0, in_ready}, 32'd1);

      $display("[TB] back-to-back requests");
      a = 16'h0102; b = 16'h0304; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      acceptat = 0;
      t = 0;
      readyat = -1;
      while (t < 20 && readyat < 0) begin
         if (t < 3) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
         end else begin
            a = 16'hA000; b = 16'h6000; cin = 1'b0;
         end
         if (out_valid) begin
            checkOutput("b2b_first_sum", {16'b0, sum}, 32'h0407);
            checkOutput("b2b_first_cout", {31'b0, cout}, 32'd0);
         end
         if (in_ready) readyat = t;
         if (readyat < 0) begin
            step();
            t++;
         end
      end
      checkOutput("b2b_spacing", readyat + 1 - acceptat, NSLICE + 2);
      step();
      in_valid = 1'b0;
      checkOutput("b2b_second_accepted", {31'b0, in_ready}, 32'd0);
      t = 0;
      while (!out_valid && t < 20) begin
         step();
         t++;
      end
      checkOutput("b2b_second_latency", t, NSLICE);
      checkOutput("b2b_second_sum", {16'b0, sum}, 32'h0000);
      checkOutput("b2b_second_cout", {31'b0, cout}, 32'd1);
      step();
      out_ready = 1'b0;

      $display("[TB] randomized operations");
      for (int i = 0; i < 24; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         if (i == 0) begin
            ra = '1;
            rb = '0;
            rc = 1'b1;
         end
         model = {1'b0, ra} + {1'b0, rb} + (WIDTH + 1)'(rc);
         applyStimulus(ra, rb, rc, $urandom_range(0, 3), model[WIDTH-1:0], model[WIDTH]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
